enigma_lampboard_renderer: RTL
==============================

Name: enigma_lampboard_renderer

Overview:
Parametrised pixel renderer for the Enigma keyboard and lampboard panels.
- Takes raster timing from video_sig_gen and draws two panels of 26 circular keys in the 9/8/9 QWERTZ layout: keyboard (panel 0) and lampboard (panel 1).
- Replaces the sprite-based display with procedural discs, rings and highlight colours.
- Adds frame-synchronous letter latching and a lamp display mode: steady, hold-timer or blink.

Parameters:
X0, 82, x of column-0 key centre, rows 0 and 2
Y0, 63, y of row-0 key centre, panel 0
PITCH, 140, horizontal centre spacing; row 1 is offset by PITCH/2
ROW_DY, 100, vertical spacing between rows
PANEL_DY, 360, vertical offset of panel 1 from panel 0
RADIUS, 35, key radius in pixels
RING_W, 3, outline ring width
HOLD_FRAMES, 30, lamp on-time in frames for mode 1
BLINK_SHIFT, 4, blink half-period is 2^BLINK_SHIFT frames
KEY_RGB, 24'h404040, unlit key fill colour
RING_RGB, 24'hC8C8C8, outline ring colour
KEY_HL_RGB, 24'h3232C8, highlighted keyboard key fill
LIT_RGB, 24'hFFD040, lit lamp fill

Ports:
clk_pixel  in  1  pixel clock
sys_rst_pixel  in  1  synchronous active-high reset
hcount_in  in  11  raster x
vcount_in  in  10  raster y
hsync_in  in  1  horizontal sync
vsync_in  in  1  vertical sync
active_draw_in  in  1  active video
new_frame_in  in  1  one-cycle pulse at frame start
key_letter_in  in  5  pressed key, 1..26 = A..Z, 0 = none
lamp_letter_in  in  5  encoded letter to light, same coding
letter_valid_in  in  1  strobe: capture key_letter_in, lamp_letter_in, mode_in
mode_in  in  2  0 steady, 1 hold, 2 blink, 3 treated as 0
red_out  out  8  pixel red
green_out  out  8  pixel green
blue_out  out  8  pixel blue
hsync_out  out  1  delayed hsync
vsync_out  out  1  delayed vsync
active_draw_out  out  1  delayed active_draw

Behaviour:
- Clocking and reset: single clock clk_pixel. Reset sys_rst_pixel is synchronous and active-high.
- Reset values: all outputs 0; shadow and committed letters 0; mode 0; hold counter 0; frame counter 0; pipeline contents 0.
- Latency: exactly 4 cycles from hcount_in/vcount_in/syncs to all outputs. hsync/vsync/active_draw are delayed identically.
- Layout rows, left to right, with letter codes:
  - Row 0: Q W E R T Z U I O = 17, 23, 5, 18, 20, 26, 21, 9, 15.
  - Row 1: A S D F G H J K = 1, 19, 4, 6, 7, 8, 10, 11.
  - Row 2: P Y X C V B N M L = 16, 25, 24, 3, 22, 2, 14, 13, 12.
- Key centre: cx = X0 + col*PITCH + (row==1 ? PITCH/2 : 0); cy = Y0 + row*ROW_DY + panel*PANEL_DY.
- Hit test: |dx|, |dy| 11-bit unsigned absolute differences; d2 = dx^2 + dy^2, 23 bits, no truncation. The pixel belongs to a key iff d2 < RADIUS^2.
  - Key search may use parallel comparators or subtract stages; latency stays 4.
  - Parameters guarantee PITCH >= 2*RADIUS, so at most one key matches.
- Colour selection:
  - Not in any key, or active_draw delayed = 0: output 0,0,0.
  - In key, d2 >= (RADIUS-RING_W)^2: RING_RGB.
  - Else panel 0: KEY_HL_RGB if the key code equals committed key letter, else KEY_RGB.
  - Else panel 1: LIT_RGB if the key code equals committed lamp letter and lamp_on, else KEY_RGB.
- Letter latching:
  - letter_valid_in writes the shadow registers.
  - On new_frame_in, shadows commit to the active registers, so there is no tearing mid-frame.
  - letter_valid_in and new_frame_in in the same cycle: the incoming values are committed that cycle.
- Code handling: codes 0 or 27..31 light nothing.
- Frame counter: increments on each new_frame_in (wraps).
- lamp_on:
  - Mode 0: 1.
  - Mode 1: hold counter != 0.
  - Mode 2: frame_cnt[BLINK_SHIFT] == 0.
- Hold counter:
  - Set to HOLD_FRAMES on a commit whose shadow was written since the last commit (retrigger, including the same letter).
  - Otherwise decrements on new_frame_in, saturating at 0.
- Reset mid-frame: outputs go to 0 next cycle. Valid data resumes 4 cycles after reset deasserts.

Test Plan:
- Reset, then drive hcount 82, vcount 63, active 1, committed key_letter 17 -> after 4 cycles RGB = 32,32,C8 (Q highlighted); same pixel with key_letter 5 -> 40,40,40.
- Lamp panel, mode 0, lamp_letter 12, pixel (1202, 623) -> FF,D0,40; pixel (1202+35, 623) -> 0,0,0 (d2 = 1225 not < 1225); pixel (1202+33, 623) -> C8,C8,C8 ring.
- Row 1 offset: pixel (1132, 163), key_letter 11 -> KEY_HL_RGB (K key); pixel (1272, 163) -> black (no ninth key in row 1).
- Mode 1, lamp_letter 5 strobed, then 35 frames, pixel (362, 423) -> LIT_RGB for the 30 frames following commit, KEY_RGB from frame 31 on; re-strobing 5 at frame 20 extends to frame 50.
- Mode 2, lamp_letter 1 -> A lamp alternates 16 frames lit / 16 frames unlit, starting lit at frame_cnt 0.
- Strobe letter_valid mid-frame with new lamp letter -> old letter drawn until next new_frame_in; simultaneous strobe and new_frame_in -> new letter drawn in that frame; hsync/vsync/active_draw outputs equal inputs delayed 4 cycles throughout.

Source files
------------

// File: rtl/enigma_lampboard_renderer_if.sv
// Pixel-side bundle of the Enigma panel renderer: raster timing and letter control in, RGB and delayed syncs out.
interface enigma_lampboard_renderer_if;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        hsync_in;
    logic        vsync_in;
    logic        active_draw_in;
    logic        new_frame_in;
    logic [4:0]  key_letter_in;
    logic [4:0]  lamp_letter_in;
    logic        letter_valid_in;
    logic [1:0]  mode_in;
    logic [7:0]  red_out;
    logic [7:0]  green_out;
    logic [7:0]  blue_out;
    logic        hsync_out;
    logic        vsync_out;
    logic        active_draw_out;

    modport master (
        output hcount_in, vcount_in, hsync_in, vsync_in, active_draw_in, new_frame_in,
        output key_letter_in, lamp_letter_in, letter_valid_in, mode_in,
        input  red_out, green_out, blue_out, hsync_out, vsync_out, active_draw_out
    );

    modport slave (
        input  hcount_in, vcount_in, hsync_in, vsync_in, active_draw_in, new_frame_in,
        input  key_letter_in, lamp_letter_in, letter_valid_in, mode_in,
        output red_out, green_out, blue_out, hsync_out, vsync_out, active_draw_out
    );
endinterface

// File: rtl/enigma_lampboard_renderer.sv
// Procedural renderer for the Enigma keyboard (panel 0) and lampboard (panel 1): 26 discs per panel,
// 4-cycle pixel pipeline, frame-synchronous letter commit and steady/hold/blink lamp modes.
module enigma_lampboard_renderer #(
    parameter int          X0          = 82,
    parameter int          Y0          = 63,
    parameter int          PITCH       = 140,
    parameter int          ROW_DY      = 100,
    parameter int          PANEL_DY    = 360,
    parameter int          RADIUS      = 35,
    parameter int          RING_W      = 3,
    parameter int          HOLD_FRAMES = 30,
    parameter int          BLINK_SHIFT = 4,
    parameter logic [23:0] KEY_RGB     = 24'h404040,
    parameter logic [23:0] RING_RGB    = 24'hC8C8C8,
    parameter logic [23:0] KEY_HL_RGB  = 24'h3232C8,
    parameter logic [23:0] LIT_RGB     = 24'hFFD040
) (
    input logic                         clk_pixel,
    input logic                         sys_rst_pixel,
    enigma_lampboard_renderer_if.slave  vid
);

    // Distinct key-centre x positions: 9 for rows 0/2, then 8 half-pitch-offset ones for row 1.
    localparam int NXPOS   = 17;
    localparam int NROWS   = 6;
    localparam int HOLD_W  = $clog2(HOLD_FRAMES + 1);
    localparam int FRAME_W = (BLINK_SHIFT >= 15) ? BLINK_SHIFT + 1 : 16;

    localparam logic [22:0] R2     = 23'(RADIUS * RADIUS);
    localparam logic [22:0] INNER2 = 23'((RADIUS - RING_W) * (RADIUS - RING_W));

    // Letter codes in row-major 3x9 order; row 1 slot 8 is empty.
    localparam logic [4:0] KEY_CODES [0:26] = '{
        5'd17, 5'd23, 5'd5,  5'd18, 5'd20, 5'd26, 5'd21, 5'd9,  5'd15,
        5'd1,  5'd19, 5'd4,  5'd6,  5'd7,  5'd8,  5'd10, 5'd11, 5'd0,
        5'd16, 5'd25, 5'd24, 5'd3,  5'd22, 5'd2,  5'd14, 5'd13, 5'd12
    };

    function automatic logic [10:0] x_pos(input int idx);
        if (idx < 9)
            return 11'(X0 + idx * PITCH);
        else
            return 11'(X0 + (idx - 9) * PITCH + PITCH / 2);
    endfunction

    function automatic logic [10:0] y_pos(input int row6);
        return 11'(Y0 + (row6 % 3) * ROW_DY + (row6 / 3) * PANEL_DY);
    endfunction

    logic [10:0] s0_h;
    logic [10:0] s0_v;
    logic [2:0]  s0_sync;

    logic [21:0] dx_sq [NXPOS];
    logic [21:0] dy_sq [NROWS];
    logic [21:0] s1_dx_sq [NXPOS];
    logic [21:0] s1_dy_sq [NROWS];
    logic [2:0]  s1_sync;

    logic        hit;
    logic [4:0]  hit_code;
    logic        hit_panel;
    logic        hit_ring;
    logic        s2_hit;
    logic [4:0]  s2_code;
    logic        s2_panel;
    logic        s2_ring;
    logic [2:0]  s2_sync;

    logic [4:0]  shadow_key;
    logic [4:0]  shadow_lamp;
    logic [1:0]  shadow_mode;
    logic        shadow_dirty;
    logic [4:0]  act_key;
    logic [4:0]  act_lamp;
    logic [1:0]  act_mode;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [FRAME_W-1:0] frame_cnt;
    logic        lamp_on;
    logic [23:0] pix_rgb;

    // Stage 0: register raster inputs; sync bits kept as {active, vsync, hsync}.
    always_ff @(posedge clk_pixel) begin
        if (sys_rst_pixel) begin
            s0_h    <= '0;
            s0_v    <= '0;
            s0_sync <= '0;
        end else begin
            s0_h    <= vid.hcount_in;
            s0_v    <= {1'b0, vid.vcount_in};
            s0_sync <= {vid.active_draw_in, vid.vsync_in, vid.hsync_in};
        end
    end

    // Squared distances are separable, so only 17 column and 6 row squares are needed.
    always_comb begin
        logic [10:0] a;
        a = '0;
        for (int i = 0; i < NXPOS; i++) begin
            a        = (s0_h >= x_pos(i)) ? s0_h - x_pos(i) : x_pos(i) - s0_h;
            dx_sq[i] = 22'(a) * 22'(a);
        end
        for (int r = 0; r < NROWS; r++) begin
            a        = (s0_v >= y_pos(r)) ? s0_v - y_pos(r) : y_pos(r) - s0_v;
            dy_sq[r] = 22'(a) * 22'(a);
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (sys_rst_pixel) begin
            for (int i = 0; i < NXPOS; i++) s1_dx_sq[i] <= '0;
            for (int r = 0; r < NROWS; r++) s1_dy_sq[r] <= '0;
            s1_sync <= '0;
        end else begin
            for (int i = 0; i < NXPOS; i++) s1_dx_sq[i] <= dx_sq[i];
            for (int r = 0; r < NROWS; r++) s1_dy_sq[r] <= dy_sq[r];
            s1_sync <= s0_sync;
        end
    end

    // Key spacing guarantees at most one disc contains the pixel, so last-match wins is safe.
    always_comb begin
        logic [22:0] d2;
        d2        = '0;
        hit       = 1'b0;
        hit_code  = '0;
        hit_panel = 1'b0;
        hit_ring  = 1'b0;
        for (int r6 = 0; r6 < NROWS; r6++) begin
            for (int c = 0; c < 9; c++) begin
                if (!((r6 % 3) == 1 && c == 8)) begin
                    d2 = {1'b0, s1_dx_sq[((r6 % 3) == 1) ? 9 + c : c]} + {1'b0, s1_dy_sq[r6]};
                    if (d2 < R2) begin
                        hit       = 1'b1;
                        hit_code  = KEY_CODES[(r6 % 3) * 9 + c];
                        hit_panel = (r6 >= 3);
                        hit_ring  = (d2 >= INNER2);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (sys_rst_pixel) begin
            s2_hit   <= 1'b0;
            s2_code  <= '0;
            s2_panel <= 1'b0;
            s2_ring  <= 1'b0;
            s2_sync  <= '0;
        end else begin
            s2_hit   <= hit;
            s2_code  <= hit_code;
            s2_panel <= hit_panel;
            s2_ring  <= hit_ring;
            s2_sync  <= s1_sync;
        end
    end

    // Shadow letters commit on frame start; a strobe in the same cycle bypasses the shadow.
    always_ff @(posedge clk_pixel) begin
        if (sys_rst_pixel) begin
            shadow_key   <= '0;
            shadow_lamp  <= '0;
            shadow_mode  <= '0;
            shadow_dirty <= 1'b0;
            act_key      <= '0;
            act_lamp     <= '0;
            act_mode     <= '0;
            hold_cnt     <= '0;
            frame_cnt    <= '0;
        end else begin
            if (vid.letter_valid_in) begin
                shadow_key   <= vid.key_letter_in;
                shadow_lamp  <= vid.lamp_letter_in;
                shadow_mode  <= vid.mode_in;
                shadow_dirty <= 1'b1;
            end
            if (vid.new_frame_in) begin
                frame_cnt    <= frame_cnt + 1'b1;
                shadow_dirty <= 1'b0;
                if (vid.letter_valid_in) begin
                    act_key  <= vid.key_letter_in;
                    act_lamp <= vid.lamp_letter_in;
                    act_mode <= vid.mode_in;
                end else begin
                    act_key  <= shadow_key;
                    act_lamp <= shadow_lamp;
                    act_mode <= shadow_mode;
                end
                if (vid.letter_valid_in || shadow_dirty)
                    hold_cnt <= HOLD_W'(HOLD_FRAMES);
                else if (hold_cnt != '0)
                    hold_cnt <= hold_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        lamp_on = 1'b1;
        case (act_mode)
            2'd1:    lamp_on = (hold_cnt != '0);
            2'd2:    lamp_on = (frame_cnt[BLINK_SHIFT] == 1'b0);
            default: lamp_on = 1'b1;
        endcase
    end

    // Key codes from the layout are always 1..26, so out-of-range letters never match.
    always_comb begin
        pix_rgb = 24'h000000;
        if (s2_sync[2] && s2_hit) begin
            if (s2_ring)
                pix_rgb = RING_RGB;
            else if (!s2_panel)
                pix_rgb = (s2_code == act_key) ? KEY_HL_RGB : KEY_RGB;
            else
                pix_rgb = (s2_code == act_lamp && lamp_on) ? LIT_RGB : KEY_RGB;
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (sys_rst_pixel) begin
            vid.red_out         <= '0;
            vid.green_out       <= '0;
            vid.blue_out        <= '0;
            vid.hsync_out       <= 1'b0;
            vid.vsync_out       <= 1'b0;
            vid.active_draw_out <= 1'b0;
        end else begin
            vid.red_out         <= pix_rgb[23:16];
            vid.green_out       <= pix_rgb[15:8];
            vid.blue_out        <= pix_rgb[7:0];
            vid.hsync_out       <= s2_sync[0];
            vid.vsync_out       <= s2_sync[1];
            vid.active_draw_out <= s2_sync[2];
        end
    end

endmodule
